// File: rtl/decode_control_pkg.sv
// Shared encodings for the multi-cycle decode controller: opcodes, functs,
// FSM states, ALU operations and the instruction classes the decoder produces.
package decode_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_R31  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_XOR = 2'd2,
    ALU_SLT = 2'd3
  } alu_op_t;

  typedef enum logic [3:0] {
    IC_ILLEGAL, IC_LW, IC_SW, IC_J, IC_JAL, IC_JR, IC_BNE, IC_XORI, IC_RALU
  } iclass_t;

  // True in the last state of an instruction, where the PC gets updated.
  function automatic logic is_final(input state_t s, input iclass_t c);
    case (s)
      S_EXEC:  return (c inside {IC_J, IC_JAL, IC_JR, IC_BNE, IC_ILLEGAL});
      S_MEM:   return (c == IC_SW);
      S_WB:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_control_opcode_decode.sv
// Combinational map from opcode/funct to instruction class and ALU operation.
module opcode_decode
  import decode_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output alu_op_t    alu_op
);

  always_comb begin
    iclass = IC_ILLEGAL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin iclass = IC_RALU; alu_op = ALU_ADD; end
          FN_SUB:  begin iclass = IC_RALU; alu_op = ALU_SUB; end
          FN_SLT:  begin iclass = IC_RALU; alu_op = ALU_SLT; end
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      OP_BNE:  begin iclass = IC_BNE;  alu_op = ALU_SUB; end
      OP_XORI: begin iclass = IC_XORI; alu_op = ALU_XOR; end
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/decode_control.sv
// Multi-cycle Moore control FSM: FETCH/DECODE/EXEC/MEM/WB with strobes
// decoded from the current state and the latched instruction register.
module decode_control
  import decode_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        stall,
  output logic        write_pc,
  output logic        is_branch,
  output logic        is_jump,
  output logic [15:0] branch_addr,
  output logic [25:0] jump_addr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        reg_we,
  output logic        mem_we,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        is_jr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic [2:0]  state
);

  state_t      r_state;
  logic [31:0] r_ir;
  iclass_t     w_class;
  alu_op_t     w_alu_op;
  logic        w_go;
  logic        w_active;

  opcode_decode u_opcode_decode (
    .opcode (r_ir[31:26]),
    .funct  (r_ir[5:0]),
    .iclass (w_class),
    .alu_op (w_alu_op)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else if (!stall) begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= instr;
          r_state <= S_DECODE;
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          case (w_class)
            IC_LW, IC_SW:     r_state <= S_MEM;
            IC_RALU, IC_XORI: r_state <= S_WB;
            default:          r_state <= S_FETCH;
          endcase
        end
        S_MEM:   r_state <= (w_class == IC_LW) ? S_WB : S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Side-effecting strobes are suppressed while frozen or being reset, so a
  // held state emits its pulse once, on the cycle it is finally allowed to move.
  assign w_go     = reset_n && !stall;
  assign w_active = (r_state != S_FETCH);

  assign write_pc   = w_go && is_final(r_state, w_class);
  assign is_jump    = write_pc && (w_class inside {IC_J, IC_JAL});
  assign is_jr      = write_pc && (w_class == IC_JR);
  assign is_branch  = write_pc && (w_class == IC_BNE) && !zero;

  assign reg_we     = w_go && (((r_state == S_WB) && (w_class inside {IC_LW, IC_RALU, IC_XORI}))
                             || ((r_state == S_EXEC) && (w_class == IC_JAL)));
  assign mem_we     = w_go && (r_state == S_MEM) && (w_class == IC_SW);
  assign mem_to_reg = (r_state == S_WB) && (w_class == IC_LW);
  assign illegal    = w_go && (r_state == S_EXEC) && (w_class == IC_ILLEGAL);

  assign alu_src    = w_active && (w_class inside {IC_LW, IC_SW, IC_XORI});
  assign alu_op     = w_active ? w_alu_op : ALU_ADD;
  assign reg_dst    = !w_active             ? DST_RT  :
                      (w_class == IC_RALU)  ? DST_RD  :
                      (w_class == IC_JAL)   ? DST_R31 : DST_RT;

  assign branch_addr = r_ir[15:0];
  assign jump_addr   = r_ir[25:0];
  assign rs          = r_ir[25:21];
  assign rt          = r_ir[20:16];
  assign state       = r_state;

endmodule

// File: tb/tb_decode_control.sv
// Self-checking bench: directed and random instructions against a cycle-index
// reference model derived from the instruction classes' latencies and strobes.
module tb_decode_control;
  import decode_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, zero, stall;
  logic [31:0] instr;
  logic        write_pc, is_branch, is_jump, reg_we, mem_we, mem_to_reg;
  logic        alu_src, is_jr, illegal;
  logic [15:0] branch_addr;
  logic [25:0] jump_addr;
  logic [4:0]  rs, rt;
  logic [1:0]  reg_dst, alu_op;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_J = 3, K_JAL = 4, K_JR = 5;
  localparam int K_BNE = 6, K_XORI = 7, K_ADD = 8, K_SUB = 9, K_SLT = 10;

  always #5 clk = ~clk;

  decode_control dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .zero(zero), .stall(stall),
    .write_pc(write_pc), .is_branch(is_branch), .is_jump(is_jump),
    .branch_addr(branch_addr), .jump_addr(jump_addr), .rs(rs), .rt(rt),
    .reg_we(reg_we), .mem_we(mem_we), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .is_jr(is_jr), .reg_dst(reg_dst), .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    if (op == 6'h05) return K_BNE;
    if (op == 6'h0E) return K_XORI;
    if (op == 6'h00) begin
      if (fn == 6'h20) return K_ADD;
      if (fn == 6'h22) return K_SUB;
      if (fn == 6'h2A) return K_SLT;
      if (fn == 6'h08) return K_JR;
    end
    return K_ILL;
  endfunction

  // One cycle after reset: FETCH, IR cleared, everything idle.
  task automatic post_reset_check();
    reset_n = 1'b1;
    stall   = 1'b1;
    instr   = $urandom();
    #3;
    check("rst_state", state, S_FETCH);
    check("rst_write_pc", write_pc, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_illegal", illegal, 0);
    check("rst_pc_ctl", {is_jump, is_jr, is_branch, mem_to_reg, alu_src}, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_reg_dst", reg_dst, 0);
    check("rst_ir", {rs, rt, jump_addr}, 0);
    @(posedge clk); #1;
    stall = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall   = 1'($urandom_range(0, 1));
    instr   = $urandom();
    #3;
    check("rstcyc_writes", {write_pc, reg_we, mem_we}, 0);
    @(posedge clk); #1;
    post_reset_check();
  endtask

  // mode 0: no stall, 1: random stalls, 2: two stall cycles in the 4th state.
  // abort_at: active cycle index where reset_n is pulled low (0 = never).
  task automatic run(input string name, input logic [31:0] ins, input logic z,
                     input int mode, input int abort_at);
    int k, lat, we_cyc, dst_e, aop_e, act, cyc, nst, idx;
    int seq[5];
    logic src_e, sv, rv, live, e_wpc, done;
    k      = kind_of(ins);
    lat    = (k == K_LW) ? 5 : (k inside {K_SW, K_ADD, K_SUB, K_SLT, K_XORI}) ? 4 : 3;
    we_cyc = (k == K_LW) ? 5 : (k inside {K_ADD, K_SUB, K_SLT, K_XORI}) ? 4 : (k == K_JAL) ? 3 : 0;
    dst_e  = (k inside {K_ADD, K_SUB, K_SLT}) ? 1 : (k == K_JAL) ? 2 : 0;
    aop_e  = (k inside {K_SUB, K_BNE}) ? 1 : (k == K_XORI) ? 2 : (k == K_SLT) ? 3 : 0;
    src_e  = (k inside {K_LW, K_SW, K_XORI});
    seq[0] = S_FETCH; seq[1] = S_DECODE; seq[2] = S_EXEC;
    seq[3] = (k inside {K_LW, K_SW}) ? S_MEM : S_WB;
    seq[4] = S_WB;
    act = 0; cyc = 0; nst = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      idx = act + 1;
      case (mode)
        1:       sv = ($urandom_range(0, 3) == 0);
        2:       sv = (act == 3 && nst < 2);
        default: sv = 1'b0;
      endcase
      rv      = (abort_at == idx);
      stall   = sv;
      reset_n = !rv;
      zero    = z;
      instr   = (act == 0) ? ins : $urandom();
      #3;
      live  = !sv && !rv;
      e_wpc = live && (idx == lat);
      check({name, "_state"}, state, seq[idx-1]);
      check({name, "_write_pc"}, write_pc, e_wpc);
      check({name, "_is_jump"}, is_jump, e_wpc && (k inside {K_J, K_JAL}));
      check({name, "_is_jr"}, is_jr, e_wpc && (k == K_JR));
      check({name, "_is_branch"}, is_branch, e_wpc && (k == K_BNE) && !z);
      check({name, "_reg_we"}, reg_we, live && (idx == we_cyc));
      check({name, "_mem_we"}, mem_we, live && (k == K_SW) && (idx == 4));
      check({name, "_illegal"}, illegal, live && (k == K_ILL) && (idx == 3));
      check({name, "_mem_to_reg"}, mem_to_reg, (k == K_LW) && (idx == 5));
      if (idx == 3) begin
        check({name, "_alu_op"}, alu_op, aop_e);
        check({name, "_alu_src"}, alu_src, src_e);
      end
      if (we_cyc != 0 && idx == we_cyc) check({name, "_reg_dst"}, reg_dst, dst_e);
      if (idx >= 2) begin
        check({name, "_rs_rt"}, {rs, rt}, {ins[25:21], ins[20:16]});
        check({name, "_addr"}, {branch_addr, jump_addr}, {ins[15:0], ins[25:0]});
      end
      @(posedge clk); #1;
      cyc++;
      if (sv) nst++;
      else act++;
      if (rv) begin
        done = 1'b1;
        post_reset_check();
      end else if (act == lat) begin
        done = 1'b1;
      end
    end
    if (abort_at == 0) check({name, "_latency"}, cyc, lat + nst);
    $display("%s instr=0x%08h zero=%0d cycles=%0d stalls=%0d", name, ins, z, cyc, nst);
  endtask

  logic [5:0]  ops[10] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h05, 6'h0E, 6'h3F, 6'h11};
  logic [5:0]  fns[6]  = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h21, 6'h00};

  initial begin
    logic [31:0] r;
    reset_n = 1'b0; stall = 1'b0; zero = 1'b0; instr = '0;
    @(posedge clk); #1;
    do_reset();

    run("add",      32'h00221820, 1'b0, 0, 0);
    run("lw",       32'h8C220004, 1'b0, 0, 0);
    run("bne_nz",   32'h14220003, 1'b0, 0, 0);
    run("bne_z",    32'h14220003, 1'b1, 0, 0);
    run("jal",      32'h0C000010, 1'b0, 0, 0);
    run("sw_stall", 32'hAC220008, 1'b0, 2, 0);
    run("lw_rst",   32'h8C220004, 1'b0, 0, 4);
    run("ill_3f",   32'hFC000000, 1'b0, 0, 0);
    run("ir_zero",  32'h00000000, 1'b0, 0, 0);
    run("add_rst",  32'h00221820, 1'b0, 0, 4);
    run("sub",      32'h00430822, 1'b1, 0, 0);
    run("slt",      32'h0064282A, 1'b0, 0, 0);
    run("xori",     32'h3841FFFF, 1'b0, 0, 0);
    run("j",        32'h0BFFFFFF, 1'b0, 0, 0);
    run("jr",       32'h03E00008, 1'b0, 1, 0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom();
      r[31:26] = ops[$urandom_range(0, 9)];
      if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 5)];
      if (n % 20 == 19) do_reset();
      run("rand", r, 1'($urandom_range(0, 1)), 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_control.md
DECODE_CONTROL -- requirements
Module: decode_control

Interface
REQ-001 SHALL have clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have reset_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have instr  in  32  fetched instruction encoding, valid while state is FETCH.
REQ-004 SHALL have zero  in  1  ALU zero flag, sampled in EXEC.
REQ-005 SHALL have stall  in  1  freeze request; high holds state, IR and all strobes.
REQ-006 SHALL have write_pc, is_branch, is_jump  out  1 each  PC-update controls for the fetch stage.
REQ-007 SHALL have branch_addr  out  16  IR[15:0]; jump_addr  out  26  IR[25:0].
REQ-008 SHALL have rs, rt  out  5 each  register-file read addresses from IR.
REQ-009 SHALL have reg_we, mem_we, mem_to_reg, alu_src, is_jr  out  1 each  datapath strobes.
REQ-010 SHALL have reg_dst  out  2  write target: 0=rt, 1=rd, 2=r31.
REQ-011 SHALL have alu_op  out  2  0=ADD, 1=SUB, 2=XOR, 3=SLT.
REQ-012 SHALL have illegal  out  1  one-cycle pulse on an unsupported encoding; state  out  3  current FSM state.

Function
REQ-013 SHALL implement Moore FSM states FETCH, DECODE, EXEC, MEM, WB; outputs decoded from state plus IR only.
REQ-014 SHALL capture instr into IR on the FETCH->DECODE edge; IR SHALL hold until the next FETCH.
REQ-015 SHALL support LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E, R-type (opcode 0x00) with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
REQ-016 Transitions: FETCH->DECODE->EXEC always; then LW/SW->MEM, R-ALU/XORI->WB, J/JAL/JR/BNE/illegal->FETCH; MEM->WB for LW, MEM->FETCH for SW; WB->FETCH.
REQ-017 Latency SHALL be: LW 5 cycles, SW/R-ALU/XORI 4 cycles, J/JAL/JR/BNE/illegal 3 cycles.
REQ-018 write_pc SHALL pulse exactly one cycle per instruction, in its final state.
REQ-019 is_jump SHALL be high with write_pc for J, JAL; is_jr with write_pc for JR.
REQ-020 is_branch SHALL be high with write_pc only for BNE with zero=0; BNE with zero=1 SHALL take the +4 path.
REQ-021 alu_op: SUB in EXEC for BNE and SUB; XOR for XORI; SLT for SLT; ADD otherwise. alu_src=1 for LW/SW/XORI.
REQ-022 mem_we SHALL be high only in MEM for SW; mem_to_reg high only in WB for LW.
REQ-023 reg_we SHALL be high for one cycle: WB for LW/R-ALU/XORI, EXEC for JAL (reg_dst=2); reg_dst=1 for R-ALU, 0 for LW/XORI.
REQ-024 Illegal opcode/funct (including IR=0) SHALL pulse illegal in EXEC, assert no reg_we/mem_we, and advance PC by 4.
REQ-025 While stall=1, state and IR SHALL hold and write_pc, reg_we, mem_we SHALL be forced 0; strobes resume on release without a duplicate pulse.
REQ-026 stall and reset_n low in the same cycle: reset SHALL win.

Reset
REQ-027 reset_n low at posedge SHALL set state=FETCH, IR=0; all strobes 0, alu_op=0, reg_dst=0 the following cycle.
REQ-028 Reset mid-instruction (any state) SHALL abort it with no pending write_pc, reg_we or mem_we emitted.

Structure
REQ-029 Opcode/funct constants, state encoding and alu_op encoding SHALL live in a shared package used by the datapath.
REQ-030 A combinational sub-module opcode_decode SHALL map IR to instruction class and alu_op; the FSM SHALL stay in decode_control.

Verification
REQ-031 ADD $3,$1,$2 (0x00221820): write_pc cycle 4 only; reg_we=1, reg_dst=1, alu_op=0 in WB; rs=1, rt=2.
REQ-032 LW (0x8C220004): 5 cycles; alu_src=1 in EXEC, mem_to_reg=1 and reg_we=1 in WB; mem_we never 1.
REQ-033 BNE (0x14220003): zero=0 -> is_branch=1, branch_addr=0x0003 with write_pc in cycle 3; zero=1 -> is_branch=0.
REQ-034 JAL (0x0C000010): cycle 3 is_jump=1, jump_addr=0x0000010, reg_we=1, reg_dst=2.
REQ-035 SW with stall=1 for 2 cycles in MEM: completes in 6 cycles, mem_we and write_pc each exactly one pulse.
REQ-036 reset_n=0 during MEM of LW: next cycle state=FETCH, all strobes 0; opcode 0x3F -> illegal pulse, no writes, 3 cycles.
